vp_text_render: RTL and testbench
=================================

VP_TEXT_RENDER -- requirements
Module: vp_text_render

Interface
REQ-001 Parameter BLINK_BIT, default 5: index of the frame-counter bit that sets the blink phase; legal range 1..7.
REQ-002 clk  in  1  pixel clock; one clock, every register is on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 frame_start  in  1  one-cycle pulse at the first pixel of each frame.
REQ-005 char_start  in  1  one-cycle pulse; txt_* inputs are valid this cycle for a new 16-pixel cell.
REQ-006 underline_row  in  1  high while the current scanline is a character's underline row.
REQ-007 txt_foreground / txt_background  in  4 / 4  color indexes.
REQ-008 txt_horz_size, txt_horz_part  in  1, 1  double-width enable; half select (0 = left, 1 = right).
REQ-009 txt_pattern / txt_border  in  16 / 16  glyph row and border row; bit 15 is the leftmost pixel.
REQ-010 txt_func  in  2  overlay mode; txt_blink, txt_invert, txt_underline, txt_enable  in  1 each.
REQ-011 pixel_color  out  4  rendered color index; pixel_valid  out  1  pixel_color is meaningful.

Function
REQ-012 On char_start, all txt_* inputs SHALL be captured into a cell register and the 4-bit pixel index SHALL be set to 0.
REQ-013 Output latency SHALL be exactly 1 cycle: the pixel for index i SHALL appear on the cycle after index i is current.
- The char_start cycle carries index 0.
- Pixel 0 therefore appears in the cycle after char_start.
REQ-014 The pixel index SHALL increment once per cycle after load and stop at 15.
- After index 15, pixel_valid SHALL drop to 0 until the next char_start.
REQ-015 A char_start while the index is below 15 SHALL abort the current cell and reload it. The new cell SHALL win; there is no mixed pixel.
REQ-016 Source bit selection:
- horz_size = 0: bit = pattern[15 - i].
- horz_size = 1: bit = pattern[15 - (8*horz_part + i/2)].
- The same indexing SHALL apply to border.
REQ-017 Overlay by txt_func, giving "on":
- 00: on = pattern bit.
- 01: on = pattern OR border.
- 10: on = pattern XOR border.
- 11: on = border bit.
REQ-018 Blink: if txt_blink = 1 and blink_phase = 1, on SHALL be forced to 0.
REQ-019 Underline: if txt_underline = 1 and underline_row = 1, on SHALL be forced to 1. This applies after blink, so underline is not suppressed by blink.
REQ-020 Invert: if txt_invert = 1, foreground and background SHALL swap before color selection.
REQ-021 Color selection: pixel_color = on ? foreground : background.
REQ-022 If the captured txt_enable = 0, pixel_color SHALL be 0 and pixel_valid SHALL be 0 for the whole cell.
REQ-023 Blink counter:
- 8-bit frame counter, incremented on each frame_start, wraps 255 -> 0.
- blink_phase = counter[BLINK_BIT].
REQ-024 If frame_start and char_start occur in the same cycle, both SHALL take effect. The new blink_phase SHALL apply from the following cycle's pixel onward.
REQ-025 underline_row SHALL be sampled live each cycle and not captured at char_start.

Reset
REQ-026 While reset is high, the following SHALL be forced to 0 and all other inputs ignored:
- pixel_color, pixel_valid.
- Frame counter, cell register.
- Pixel index, which SHALL be held at 15 (idle).
REQ-027 Reset asserted mid-cell SHALL abort the cell. pixel_valid SHALL be 0 in the cycle after reset is sampled and remain 0 until a char_start after reset is released.

Verification
REQ-028 Single-width cell:
- Stimulus: char_start with pattern = 16'hA5F0, fg = 4'hF, bg = 4'h1, func = 00, enable = 1.
- Response: 16 valid pixels, starting next cycle, colors F,1,F,1,1,F,1,F,F,F,F,F,1,1,1,1; then pixel_valid = 0.
REQ-029 Double width, right half:
- Stimulus: pattern = 16'h00C3, horz_size = 1, horz_part = 1.
- Response: pixel pairs fg,fg,fg,fg,bg×8,fg,fg,fg,fg.
REQ-030 Func and invert:
- Stimulus: pattern = 16'hFF00, border = 16'h0FF0, func = 10, invert = 1, fg = 2, bg = 7.
- Response: on = 16'hF0F0 yields 7×4, 2×4, 7×4, 2×4.
REQ-031 Blink versus underline:
- Stimulus: blink = 1, underline = 1, 32 frame_start pulses (BLINK_BIT = 5).
- Response: with underline_row = 0, the cell renders all bg; with underline_row = 1, all fg.
- After 32 more frames, the glyph is visible again.
REQ-032 Restart and reset:
- Stimulus 1: char_start at index 6 with new fg = 3. Response: the next pixel is the new cell's pixel 0, with no stale pixel.
- Stimulus 2: reset at index 9. Response: pixel_valid = 0 the next cycle; the frame counter reads 0.

Source files
------------

// File: rtl/vp_text_render.sv
// Text-mode pixel renderer: turns one captured 16-pixel character cell into a
// stream of colour indexes, with overlay, blink, underline and invert effects.
module vp_text_render #(
  parameter int BLINK_BIT = 5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_frame_start,
  input  logic        i_char_start,
  input  logic        i_underline_row,
  input  logic [3:0]  i_txt_foreground,
  input  logic [3:0]  i_txt_background,
  input  logic        i_txt_horz_size,
  input  logic        i_txt_horz_part,
  input  logic [15:0] i_txt_pattern,
  input  logic [15:0] i_txt_border,
  input  logic [1:0]  i_txt_func,
  input  logic        i_txt_blink,
  input  logic        i_txt_invert,
  input  logic        i_txt_underline,
  input  logic        i_txt_enable,
  output logic [3:0]  o_pixel_color,
  output logic        o_pixel_valid
);

  logic [3:0]  r_fg;
  logic [3:0]  r_bg;
  logic        r_horzSize;
  logic        r_horzPart;
  logic [15:0] r_pattern;
  logic [15:0] r_border;
  logic [1:0]  r_func;
  logic        r_blink;
  logic        r_invert;
  logic        r_underline;
  logic        r_enable;
  logic [3:0]  r_idx;
  logic [7:0]  r_frameCnt;

  logic [3:0]  w_fg;
  logic [3:0]  w_bg;
  logic        w_horzSize;
  logic        w_horzPart;
  logic [15:0] w_pattern;
  logic [15:0] w_border;
  logic [1:0]  w_func;
  logic        w_blink;
  logic        w_invert;
  logic        w_underline;
  logic        w_enable;
  logic        w_run;
  logic [3:0]  w_idx;
  logic [3:0]  w_srcIdx;
  logic [3:0]  w_bitPos;
  logic        w_patBit;
  logic        w_borBit;
  logic        w_on;
  logic        w_blinkPhase;
  logic [3:0]  w_color;
  logic        w_valid;

  // The char_start cycle renders pixel 0 straight from the inputs, so a new
  // cell always wins over a cell still in flight.
  always_comb begin
    w_fg        = r_fg;
    w_bg        = r_bg;
    w_horzSize  = r_horzSize;
    w_horzPart  = r_horzPart;
    w_pattern   = r_pattern;
    w_border    = r_border;
    w_func      = r_func;
    w_blink     = r_blink;
    w_invert    = r_invert;
    w_underline = r_underline;
    w_enable    = r_enable;
    w_run       = (r_idx != 4'd15);
    w_idx       = r_idx + 4'd1;
    if (i_char_start) begin
      w_fg        = i_txt_foreground;
      w_bg        = i_txt_background;
      w_horzSize  = i_txt_horz_size;
      w_horzPart  = i_txt_horz_part;
      w_pattern   = i_txt_pattern;
      w_border    = i_txt_border;
      w_func      = i_txt_func;
      w_blink     = i_txt_blink;
      w_invert    = i_txt_invert;
      w_underline = i_txt_underline;
      w_enable    = i_txt_enable;
      w_run       = 1'b1;
      w_idx       = 4'd0;
    end
  end

  // Double width walks one half of the row at half speed.
  always_comb begin
    w_srcIdx     = w_horzSize ? {w_horzPart, w_idx[3:1]} : w_idx;
    w_bitPos     = 4'd15 - w_srcIdx;
    w_patBit     = w_pattern[w_bitPos];
    w_borBit     = w_border[w_bitPos];
    w_blinkPhase = r_frameCnt[BLINK_BIT];
    case (w_func)
      2'b00:   w_on = w_patBit;
      2'b01:   w_on = w_patBit | w_borBit;
      2'b10:   w_on = w_patBit ^ w_borBit;
      default: w_on = w_borBit;
    endcase
    if (w_blink && w_blinkPhase) w_on = 1'b0;
    if (w_underline && i_underline_row) w_on = 1'b1;
    if (w_invert) w_color = w_on ? w_bg : w_fg;
    else          w_color = w_on ? w_fg : w_bg;
    w_valid = w_run && w_enable;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fg          <= 4'd0;
      r_bg          <= 4'd0;
      r_horzSize    <= 1'b0;
      r_horzPart    <= 1'b0;
      r_pattern     <= 16'd0;
      r_border      <= 16'd0;
      r_func        <= 2'd0;
      r_blink       <= 1'b0;
      r_invert      <= 1'b0;
      r_underline   <= 1'b0;
      r_enable      <= 1'b0;
      r_idx         <= 4'd15;
      r_frameCnt    <= 8'd0;
      o_pixel_color <= 4'd0;
      o_pixel_valid <= 1'b0;
    end else begin
      if (i_frame_start) r_frameCnt <= r_frameCnt + 8'd1;
      if (i_char_start) begin
        r_fg        <= i_txt_foreground;
        r_bg        <= i_txt_background;
        r_horzSize  <= i_txt_horz_size;
        r_horzPart  <= i_txt_horz_part;
        r_pattern   <= i_txt_pattern;
        r_border    <= i_txt_border;
        r_func      <= i_txt_func;
        r_blink     <= i_txt_blink;
        r_invert    <= i_txt_invert;
        r_underline <= i_txt_underline;
        r_enable    <= i_txt_enable;
      end
      r_idx         <= w_run ? w_idx : 4'd15;
      o_pixel_valid <= w_valid;
      o_pixel_color <= w_valid ? w_color : 4'd0;
    end
  end

endmodule

// File: tb/tb_vp_text_render.sv
// Scoreboard bench for vp_text_render: stimulus pushes expected pixels from a
// row-level reference model, a negedge monitor pops and compares.
module tb_vp_text_render;

  typedef struct {
    logic [3:0]  fg;
    logic [3:0]  bg;
    logic        hs;
    logic        hp;
    logic [15:0] pat;
    logic [15:0] bor;
    logic [1:0]  func;
    logic        blink;
    logic        inv;
    logic        ul;
    logic        en;
  } cell_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        frameStart;
  logic        charStart;
  logic        underlineRow;
  logic [3:0]  txtFg;
  logic [3:0]  txtBg;
  logic        txtHs;
  logic        txtHp;
  logic [15:0] txtPat;
  logic [15:0] txtBor;
  logic [1:0]  txtFunc;
  logic        txtBlink;
  logic        txtInv;
  logic        txtUl;
  logic        txtEn;
  logic [3:0]  pixelColor;
  logic        pixelValid;

  int          nTests = 0;
  int          nFail = 0;
  int          frameCount = 0;
  logic [3:0]  expQ[$];

  vp_text_render #(.BLINK_BIT(5)) dut (
    .i_clk(clock), .i_reset(reset), .i_frame_start(frameStart),
    .i_char_start(charStart), .i_underline_row(underlineRow),
    .i_txt_foreground(txtFg), .i_txt_background(txtBg),
    .i_txt_horz_size(txtHs), .i_txt_horz_part(txtHp),
    .i_txt_pattern(txtPat), .i_txt_border(txtBor), .i_txt_func(txtFunc),
    .i_txt_blink(txtBlink), .i_txt_invert(txtInv),
    .i_txt_underline(txtUl), .i_txt_enable(txtEn),
    .o_pixel_color(pixelColor), .o_pixel_valid(pixelValid)
  );

  always #5 clock = ~clock;

  // Expand a glyph row to the 16 displayed pixels (leftmost first = bit 15).
  function automatic logic [15:0] widen(logic [15:0] row, logic hs, logic hp);
    logic [7:0]  half;
    logic [15:0] outRow;
    if (!hs) return row;
    half = hp ? row[7:0] : row[15:8];
    for (int k = 0; k < 8; k++) begin
      outRow[15-2*k] = half[7-k];
      outRow[14-2*k] = half[7-k];
    end
    return outRow;
  endfunction

  function automatic logic [3:0] modelPixel(cell_t c, int i, bit phase, bit ulRow);
    logic [15:0] p, b;
    bit on;
    logic [3:0] f, g;
    p = widen(c.pat, c.hs, c.hp);
    b = widen(c.bor, c.hs, c.hp);
    case (c.func)
      2'd0: on = p[15-i];
      2'd1: on = p[15-i] | b[15-i];
      2'd2: on = p[15-i] ^ b[15-i];
      default: on = b[15-i];
    endcase
    if (c.blink && phase) on = 0;
    if (c.ul && ulRow) on = 1;
    f = c.inv ? c.bg : c.fg;
    g = c.inv ? c.fg : c.bg;
    return on ? f : g;
  endfunction

  task automatic checkOutput(string name, logic [3:0] act, logic [3:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (pixelValid === 1'b1) begin
      if (expQ.size() == 0) begin
        nTests++;
        nFail++;
        $display("[TB] FAIL extraPixel: got valid color %h expected no pixel at %0t", pixelColor, $time);
      end else begin
        checkOutput("pixel", pixelColor, expQ.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a cell and let it run nPix cycles (fewer than 16 means it is cut short).
  task automatic applyStimulus(cell_t c, int nPix, bit ulRow, bit useModel = 1);
    bit phase;
    phase = frameCount[5];
    underlineRow = ulRow;
    if (c.en && useModel)
      for (int i = 0; i < nPix && i < 16; i++) expQ.push_back(modelPixel(c, i, phase, ulRow));
    txtFg = c.fg; txtBg = c.bg; txtHs = c.hs; txtHp = c.hp;
    txtPat = c.pat; txtBor = c.bor; txtFunc = c.func; txtBlink = c.blink;
    txtInv = c.inv; txtUl = c.ul; txtEn = c.en;
    charStart = 1'b1;
    for (int i = 0; i < nPix; i++) begin
      tick();
      charStart = 1'b0;
      if (!c.en && i < 16) begin
        checkOutput("disabledValid", {3'b0, pixelValid}, 4'h0);
        checkOutput("disabledColor", pixelColor, 4'h0);
      end
    end
  endtask

  task automatic frames(int n);
    for (int i = 0; i < n; i++) begin
      frameStart = 1'b1;
      tick();
      frameStart = 1'b0;
      tick();
    end
    frameCount = (frameCount + n) % 256;
  endtask

  function automatic cell_t mkCell(logic [15:0] pat, logic [3:0] fg, logic [3:0] bg);
    cell_t c;
    c.fg = fg; c.bg = bg; c.hs = 0; c.hp = 0; c.pat = pat; c.bor = 16'h0;
    c.func = 2'd0; c.blink = 0; c.inv = 0; c.ul = 0; c.en = 1;
    return c;
  endfunction

  initial begin
    cell_t c, c2;
    logic [3:0] colors028 [16] = '{4'hF,4'h1,4'hF,4'h1,4'h1,4'hF,4'h1,4'hF,
                                   4'hF,4'hF,4'hF,4'hF,4'h1,4'h1,4'h1,4'h1};
    reset = 1; frameStart = 0; charStart = 1; underlineRow = 0;
    txtFg = 4'hF; txtBg = 4'hF; txtHs = 0; txtHp = 0; txtPat = 16'hFFFF;
    txtBor = 16'hFFFF; txtFunc = 0; txtBlink = 0; txtInv = 0; txtUl = 0; txtEn = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("resetValid", {3'b0, pixelValid}, 4'h0);
      checkOutput("resetColor", pixelColor, 4'h0);
    end
    charStart = 0;
    reset = 0;
    tick();
    checkOutput("idleValid", {3'b0, pixelValid}, 4'h0);

    // Single width with fixed expected colours.
    c = mkCell(16'hA5F0, 4'hF, 4'h1);
    for (int i = 0; i < 16; i++) expQ.push_back(colors028[i]);
    applyStimulus(c, 16, 0, 0);
    tick();
    checkOutput("validDrop", {3'b0, pixelValid}, 4'h0);
    tick();

    // Double width, right half.
    c = mkCell(16'h00C3, 4'h9, 4'h4);
    c.hs = 1; c.hp = 1;
    applyStimulus(c, 16, 0);
    c.hp = 0;
    applyStimulus(c, 16, 0);
    tick();

    // XOR overlay with invert.
    c = mkCell(16'hFF00, 4'h2, 4'h7);
    c.bor = 16'h0FF0; c.func = 2'd2; c.inv = 1;
    applyStimulus(c, 16, 0);
    tick();

    // Blink versus underline.
    c = mkCell(16'hA5F0, 4'hE, 4'h3);
    c.blink = 1; c.ul = 1;
    frames(32);
    applyStimulus(c, 16, 0);
    applyStimulus(c, 16, 1);
    tick();
    frames(32);
    applyStimulus(c, 16, 0);
    tick();

    // Restart at index 6.
    c = mkCell(16'h5A3C, 4'hA, 4'h5);
    c2 = mkCell(16'hC3C3, 4'h3, 4'h6);
    applyStimulus(c, 6, 0);
    applyStimulus(c2, 16, 0);
    tick();

    // Disabled cell.
    c.en = 0;
    applyStimulus(c, 16, 0);
    tick();

    // Reset at index 9, then check blink phase came back to 0.
    frames(40);
    c = mkCell(16'hF00F, 4'hB, 4'h2);
    applyStimulus(c, 9, 0);
    reset = 1;
    tick();
    checkOutput("resetAbortValid", {3'b0, pixelValid}, 4'h0);
    reset = 0;
    frameCount = 0;
    tick();
    checkOutput("afterResetValid", {3'b0, pixelValid}, 4'h0);
    c.blink = 1;
    applyStimulus(c, 16, 0);
    tick();

    // Randomized cells, restarts and frame counts.
    for (int n = 0; n < 60; n++) begin
      c.fg = 4'($urandom); c.bg = 4'($urandom); c.hs = 1'($urandom); c.hp = 1'($urandom);
      c.pat = 16'($urandom); c.bor = 16'($urandom); c.func = 2'($urandom);
      c.blink = 1'($urandom); c.inv = 1'($urandom); c.ul = 1'($urandom);
      c.en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus(c, $urandom_range(1, 15), 1'($urandom));
        c.fg = 4'($urandom); c.pat = 16'($urandom); c.en = 1;
      end
      applyStimulus(c, 16, 1'($urandom));
      if ($urandom_range(0, 2) == 0) frames($urandom_range(1, 40));
      if ($urandom_range(0, 1) == 0) tick();
    end
    tick();
    tick();

    nTests++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("[TB] FAIL missingPixels: got %0d pixels left expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
